vector_seq_alu: RTL and testbench

Parametrised multi-cycle vector ALU for the execute stage. It is the successor to the single-cycle vector ALU. It latches two VEC_W operands, then processes LANES_PER_CYCLE elements per beat over BEATS cycles. It returns the full result through a valid/ready handshake and raises stall_request so the hazard unit holds fetch/decode while it is busy.

---
 rtl/vector_seq_pkg.sv | 28 ++
 rtl/vector_seq_alu_lane.sv | 55 +++++
 rtl/vector_seq_alu.sv | 120 ++++++++++++
 tb/tb_vector_seq_alu.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_seq_pkg.sv
// Shared types for the multi-cycle vector ALU: opcode and FSM state enums, beat-count helper.
package vector_seq_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SHL    = 5'd5,
        OP_SHR    = 5'd6,
        OP_ADDS   = 5'd7,
        OP_MUL    = 5'd8,
        OP_SATADD = 5'd9,
        OP_SATSUB = 5'd10
    } vec_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic int calc_beats(input int vec_w, input int elem_w, input int lanes);
        return vec_w / (elem_w * lanes);
    endfunction

endpackage

// File: rtl/vector_seq_alu_lane.sv
// Combinational single-element ALU lane. Saturating add/sub (ops 9/10) exist only when
// VECTOR_SEQ_SATURATE_EN is defined; otherwise those codes fall through to pass-A.
module vector_lane_alu
    import vector_seq_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int OP_W   = 5
) (
    input  logic [OP_W-1:0]   op,
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    input  logic [ELEM_W-1:0] scalar,
    output logic [ELEM_W-1:0] y
);

    localparam int SH_W = (ELEM_W > 1) ? $clog2(ELEM_W) : 1;

    logic [SH_W-1:0] shamt;
    assign shamt = scalar[SH_W-1:0];

`ifdef VECTOR_SEQ_SATURATE_EN
    function automatic logic [ELEM_W-1:0] sat_add(input logic [ELEM_W-1:0] x,
                                                  input logic [ELEM_W-1:0] z);
        logic [ELEM_W:0] sum;
        sum = {1'b0, x} + {1'b0, z};
        return sum[ELEM_W] ? {ELEM_W{1'b1}} : sum[ELEM_W-1:0];
    endfunction

    function automatic logic [ELEM_W-1:0] sat_sub(input logic [ELEM_W-1:0] x,
                                                  input logic [ELEM_W-1:0] z);
        return (x < z) ? '0 : x - z;
    endfunction
`endif

    always_comb begin
        y = a;
        case (op)
            OP_W'(OP_ADD):    y = a + b;
            OP_W'(OP_SUB):    y = a - b;
            OP_W'(OP_AND):    y = a & b;
            OP_W'(OP_OR):     y = a | b;
            OP_W'(OP_XOR):    y = a ^ b;
            OP_W'(OP_SHL):    y = a << shamt;
            OP_W'(OP_SHR):    y = a >> shamt;
            OP_W'(OP_ADDS):   y = a + scalar;
            OP_W'(OP_MUL):    y = a * b;
`ifdef VECTOR_SEQ_SATURATE_EN
            OP_W'(OP_SATADD): y = sat_add(a, b);
            OP_W'(OP_SATSUB): y = sat_sub(a, b);
`endif
            default:          y = a;
        endcase
    end

endmodule

// File: rtl/vector_seq_alu.sv
// Multi-cycle vector ALU: latches operands, computes LANES_PER_CYCLE elements per beat, then
// holds the result on a valid/ready handshake. Optional saturating ops: VECTOR_SEQ_SATURATE_EN.
module vector_seq_alu
    import vector_seq_pkg::*;
#(
    parameter int VEC_W           = 128,
    parameter int ELEM_W          = 8,
    parameter int LANES_PER_CYCLE = 4,
    parameter int OP_W            = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [OP_W-1:0]   aluVectorOp,
    input  logic [VEC_W-1:0]  srcA_vector,
    input  logic [VEC_W-1:0]  srcB_vector,
    input  logic [ELEM_W-1:0] scalar_operand,
    input  logic              flush,
    output logic [VEC_W-1:0]  result_vector,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic              stall_request
);

    localparam int NUM_ELEMS = VEC_W / ELEM_W;
    localparam int BEATS     = calc_beats(VEC_W, ELEM_W, LANES_PER_CYCLE);
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if (VEC_W % (ELEM_W * LANES_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("vector_seq_alu: VEC_W must be a multiple of ELEM_W*LANES_PER_CYCLE");
    end

    state_t                             state;
    logic [BEAT_W-1:0]                  beat_p0;
    logic [OP_W-1:0]                    op_p0;
    logic [NUM_ELEMS-1:0][ELEM_W-1:0]   src_a_p0;
    logic [NUM_ELEMS-1:0][ELEM_W-1:0]   src_b_p0;
    logic [ELEM_W-1:0]                  scalar_p0;
    logic [NUM_ELEMS-1:0][ELEM_W-1:0]   result_p1;

    logic [IDX_W-1:0]  lane_idx [LANES_PER_CYCLE];
    logic [ELEM_W-1:0] lane_y   [LANES_PER_CYCLE];

    // Beat stage: lanes pick elements beat*L+l from the latched operands.
    for (genvar l = 0; l < LANES_PER_CYCLE; l++) begin : g_lane
        assign lane_idx[l] = IDX_W'(int'(beat_p0) * LANES_PER_CYCLE + l);

        vector_lane_alu #(
            .ELEM_W (ELEM_W),
            .OP_W   (OP_W)
        ) u_lane (
            .op     (op_p0),
            .a      (src_a_p0[lane_idx[l]]),
            .b      (src_b_p0[lane_idx[l]]),
            .scalar (scalar_p0),
            .y      (lane_y[l])
        );
    end

    assign start_ready   = (state == IDLE);
    assign busy          = (state != IDLE);
    assign stall_request = busy;
    assign result_vector = result_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            beat_p0      <= '0;
            result_valid <= 1'b0;
            result_p1    <= '0;
            op_p0        <= '0;
            src_a_p0     <= '0;
            src_b_p0     <= '0;
            scalar_p0    <= '0;
        end else if (flush) begin
            state        <= IDLE;
            beat_p0      <= '0;
            result_valid <= 1'b0;
            result_p1    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        op_p0     <= aluVectorOp;
                        src_a_p0  <= srcA_vector;
                        src_b_p0  <= srcB_vector;
                        scalar_p0 <= scalar_operand;
                        beat_p0   <= '0;
                        state     <= COMPUTE;
                    end
                end
                // Result stage: each beat overwrites only its own slice of the result.
                COMPUTE: begin
                    for (int l = 0; l < LANES_PER_CYCLE; l++) begin
                        result_p1[lane_idx[l]] <= lane_y[l];
                    end
                    if (beat_p0 == LAST_BEAT) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        beat_p0      <= '0;
                    end else begin
                        beat_p0 <= beat_p0 + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_seq_alu.sv
// Self-checking bench for vector_seq_alu: a transaction-level reference model checked every
// cycle, plus directed vectors with literal expectations (default and 64-bit/8-lane builds).
module tb_vector_seq_alu;

    localparam int BEATS = 4;

    logic         clk;
    logic         reset;
    logic         start_valid;
    logic         start_ready;
    logic [4:0]   aluVectorOp;
    logic [127:0] srcA_vector;
    logic [127:0] srcB_vector;
    logic [7:0]   scalar_operand;
    logic         flush;
    logic [127:0] result_vector;
    logic         result_valid;
    logic         result_ready;
    logic         busy;
    logic         stall_request;

    logic         s1_start_valid;
    logic         s1_start_ready;
    logic [4:0]   s1_op;
    logic [63:0]  s1_a;
    logic [63:0]  s1_b;
    logic [7:0]   s1_scalar;
    logic         s1_flush;
    logic [63:0]  s1_result;
    logic         s1_valid;
    logic         s1_ready;
    logic         s1_busy;
    logic         s1_stall;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    vector_seq_alu dut (
        .clk            (clk),
        .reset          (reset),
        .start_valid    (start_valid),
        .start_ready    (start_ready),
        .aluVectorOp    (aluVectorOp),
        .srcA_vector    (srcA_vector),
        .srcB_vector    (srcB_vector),
        .scalar_operand (scalar_operand),
        .flush          (flush),
        .result_vector  (result_vector),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .busy           (busy),
        .stall_request  (stall_request)
    );

    vector_seq_alu #(.VEC_W(64), .ELEM_W(8), .LANES_PER_CYCLE(8), .OP_W(5)) dut1 (
        .clk            (clk),
        .reset          (reset),
        .start_valid    (s1_start_valid),
        .start_ready    (s1_start_ready),
        .aluVectorOp    (s1_op),
        .srcA_vector    (s1_a),
        .srcB_vector    (s1_b),
        .scalar_operand (s1_scalar),
        .flush          (s1_flush),
        .result_vector  (s1_result),
        .result_valid   (s1_valid),
        .result_ready   (s1_ready),
        .busy           (s1_busy),
        .stall_request  (s1_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] elem_ref(input logic [4:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] s);
        int x, y, r;
        x = int'(a);
        y = int'(b);
        case (op)
            5'd0:    r = x + y;
            5'd1:    r = x - y;
            5'd2:    r = x & y;
            5'd3:    r = x | y;
            5'd4:    r = x ^ y;
            5'd5:    r = x << s[2:0];
            5'd6:    r = x >> s[2:0];
            5'd7:    r = x + int'(s);
            5'd8:    r = x * y;
`ifdef VECTOR_SEQ_SATURATE_EN
            5'd9:    r = (x + y > 255) ? 255 : x + y;
            5'd10:   r = (x < y) ? 0 : x - y;
`endif
            default: r = x;
        endcase
        return r[7:0];
    endfunction

    function automatic logic [127:0] vec_ref(input logic [4:0] op, input logic [127:0] a,
                                             input logic [127:0] b, input logic [7:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = elem_ref(op, a[i*8 +: 8], b[i*8 +: 8], s);
        return r;
    endfunction

    // Transaction model: an accepted op completes BEATS edges later, then waits for ready.
    logic         m_active  = 1'b0;
    logic         m_valid   = 1'b0;
    int           m_cnt     = 0;
    logic [127:0] m_result  = '0;
    logic [127:0] m_pending = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_valid  <= 1'b0;
            m_cnt    <= 0;
            m_result <= '0;
        end else if (flush) begin
            m_active <= 1'b0;
            m_valid  <= 1'b0;
            m_cnt    <= 0;
            m_result <= '0;
        end else if (m_active) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_active <= 1'b0;
                m_valid  <= 1'b1;
                m_result <= m_pending;
            end
        end else if (m_valid) begin
            if (result_ready) m_valid <= 1'b0;
        end else if (start_valid) begin
            m_pending <= vec_ref(aluVectorOp, srcA_vector, srcB_vector, scalar_operand);
            m_active  <= 1'b1;
            m_cnt     <= BEATS;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check_bit("cyc_busy", busy, m_active | m_valid);
            check_bit("cyc_stall", stall_request, m_active | m_valid);
            check_bit("cyc_start_ready", start_ready, !(m_active | m_valid));
            check_bit("cyc_valid", result_valid, m_valid);
            if (!m_active) check_vec("cyc_result", result_vector, m_result);
        end
    end

    task automatic run_op(input string name, input logic [4:0] op, input logic [127:0] a,
                          input logic [127:0] b, input logic [7:0] s, input logic [127:0] exp);
        int n;
        start_valid    = 1'b1;
        aluVectorOp    = op;
        srcA_vector    = a;
        srcB_vector    = b;
        scalar_operand = s;
        @(posedge clk); #1;
        start_valid    = 1'b0;
        srcA_vector    = ~a;
        srcB_vector    = ~b;
        scalar_operand = ~s;
        aluVectorOp    = 5'd31;
        n = 0;
        while (!result_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
            check_bit({name, "_busy"}, busy, 1'b1);
        end
        check_int({name, "_latency"}, n, BEATS);
        check_vec({name, "_result"}, result_vector, exp);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check_bit({name, "_idle"}, busy, 1'b0);
        check_vec({name, "_retained"}, result_vector, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ramp;
        int           n;
        reset = 1'b1;
        start_valid = 1'b0; aluVectorOp = '0; srcA_vector = '0; srcB_vector = '0;
        scalar_operand = '0; flush = 1'b0; result_ready = 1'b0;
        s1_start_valid = 1'b0; s1_op = '0; s1_a = '0; s1_b = '0; s1_scalar = '0;
        s1_flush = 1'b0; s1_ready = 1'b0;
        #2 reset = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        check_vec("rst_result", result_vector, 128'h0);
        check_bit("rst_valid", result_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_start_ready", start_ready, 1'b1);

        run_op("add", 5'd0, {16{8'h05}}, {16{8'h03}}, 8'h00, {16{8'h08}});
        run_op("add_wrap", 5'd0, {16{8'hFF}}, {16{8'h02}}, 8'h00, {16{8'h01}});
        ramp = 128'h0f0e0d0c0b0a09080706050403020100;
        run_op("add_order", 5'd0, ramp, {16{8'h01}}, 8'h00, 128'h100f0e0d0c0b0a090807060504030201);
        run_op("sub_wrap", 5'd1, {16{8'h01}}, {16{8'h02}}, 8'h00, {16{8'hFF}});
        run_op("and", 5'd2, {16{8'hF0}}, {16{8'h3C}}, 8'h00, {16{8'h30}});
        run_op("or", 5'd3, {16{8'hF0}}, {16{8'h3C}}, 8'h00, {16{8'hFC}});
        run_op("xor", 5'd4, {16{8'hF0}}, {16{8'h3C}}, 8'h00, {16{8'hCC}});
        run_op("shl", 5'd5, {16{8'h81}}, {16{8'h00}}, 8'h01, {16{8'h02}});
        run_op("shl_mask", 5'd5, {16{8'h01}}, {16{8'h00}}, 8'h09, {16{8'h02}});
        run_op("shr", 5'd6, {16{8'h81}}, {16{8'h00}}, 8'h03, {16{8'h10}});
        run_op("bcast", 5'd7, {16{8'h10}}, {16{8'h00}}, 8'h22, {16{8'h32}});
        run_op("mul", 5'd8, {16{8'h13}}, {16{8'h11}}, 8'h00, {16{8'h43}});
        run_op("pass", 5'd15, {16{8'h5A}}, {16{8'hA5}}, 8'h00, {16{8'h5A}});
`ifdef VECTOR_SEQ_SATURATE_EN
        run_op("satadd", 5'd9, {16{8'hF0}}, {16{8'h20}}, 8'h00, {16{8'hFF}});
        run_op("satsub", 5'd10, {16{8'h10}}, {16{8'h20}}, 8'h00, {16{8'h00}});
`else
        run_op("satadd_off", 5'd9, {16{8'hF0}}, {16{8'h20}}, 8'h00, {16{8'hF0}});
        run_op("satsub_off", 5'd10, {16{8'h10}}, {16{8'h20}}, 8'h00, {16{8'h10}});
`endif

        // Backpressure: result held while ready is low, new requests ignored.
        start_valid = 1'b1; aluVectorOp = 5'd0;
        srcA_vector = ramp; srcB_vector = ramp;
        @(posedge clk); #1;
        start_valid = 1'b0;
        n = 0;
        while (!result_valid && n < 20) begin @(posedge clk); #1; n++; end
        check_int("bp_latency", n, BEATS);
        repeat (5) begin
            start_valid = 1'b1; aluVectorOp = 5'd4; srcA_vector = {16{8'hAA}};
            @(posedge clk); #1;
            check_bit("bp_valid", result_valid, 1'b1);
            check_bit("bp_start_ready", start_ready, 1'b0);
            check_vec("bp_result", result_vector, 128'h1e1c1a18161412100e0c0a0806040200);
        end
        start_valid = 1'b0; result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check_bit("bp_idle", busy, 1'b0);
        check_bit("bp_ready_back", start_ready, 1'b1);
        @(posedge clk); #1;
        check_bit("bp_no_accept", busy, 1'b0);

        // Flush at beat 2 discards the operation.
        start_valid = 1'b1; aluVectorOp = 5'd1;
        srcA_vector = {16{8'h33}}; srcB_vector = {16{8'h11}};
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_bit("flush_busy", busy, 1'b0);
        check_bit("flush_valid", result_valid, 1'b0);
        check_vec("flush_result", result_vector, 128'h0);
        repeat (6) begin
            @(posedge clk); #1;
            check_bit("flush_no_valid", result_valid, 1'b0);
        end
        run_op("sub_after_flush", 5'd1, {16{8'h10}}, {16{8'h01}}, 8'h00, {16{8'h0F}});

        // Flush in IDLE blocks an accept.
        start_valid = 1'b1; flush = 1'b1; aluVectorOp = 5'd0;
        @(posedge clk); #1;
        start_valid = 1'b0; flush = 1'b0;
        check_bit("flush_idle_no_accept", busy, 1'b0);

        // Asynchronous reset mid-operation.
        start_valid = 1'b1; aluVectorOp = 5'd0;
        srcA_vector = {16{8'h01}}; srcB_vector = {16{8'h01}};
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_vec("rst_mid_result", result_vector, 128'h0);
        check_bit("rst_mid_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_op("add_after_rst", 5'd0, {16{8'h20}}, {16{8'h07}}, 8'h00, {16{8'h27}});

        // 64-bit, 8-lane build completes in one beat.
        s1_start_valid = 1'b1; s1_op = 5'd0;
        s1_a = 64'h0102030405060708; s1_b = {8{8'h01}};
        @(posedge clk); #1;
        s1_start_valid = 1'b0; s1_a = '0;
        check_bit("p1_busy", s1_busy, 1'b1);
        check_bit("p1_not_yet", s1_valid, 1'b0);
        @(posedge clk); #1;
        check_bit("p1_valid", s1_valid, 1'b1);
        check_vec("p1_result", {64'h0, s1_result}, {64'h0, 64'h0203040506070809});
        s1_ready = 1'b1;
        @(posedge clk); #1;
        s1_ready = 1'b0;
        check_bit("p1_idle", s1_busy, 1'b0);
        check_bit("p1_stall", s1_stall, 1'b0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
